instruction_decode_stage: RTL and testbench

Pipeline stage between fetch and execute. Accepts raw 32-bit RV32I instruction words with their PC over a valid/ready handshake, then registers a decoded `instruction_t`, a sign-extended immediate and an illegal-instruction flag for the arithmetic logic unit and branch logic. Supports flush on redirect and sustains one instruction per cycle under back-pressure.

---
 rtl/instruction_decode_stage_pkg.sv | 44 ++++
 rtl/instruction_decode_stage_if.sv | 29 ++
 rtl/instruction_decode_stage_immediate_generator.sv | 29 ++
 rtl/instruction_decode_stage.sv | 139 +++++++++++++
 tb/tb_instruction_decode_stage.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_decode_stage_pkg.sv
// Shared RV32I definitions for the decode stage: register width, opcodes, funct7 values,
// immediate formats and the decoded instruction layout.
package common;

    localparam int REGISTER_WIDTH = 32;

    localparam logic [6:0] OPCODE_ARITH     = 7'b0110011;
    localparam logic [6:0] OPCODE_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI       = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL       = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR      = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD      = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE     = 7'b0100011;
    localparam logic [6:0] OPCODE_SYSTEM    = 7'b1110011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_t;

    // Field view of a raw word; fields not used by a format are simply carried along.
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_t;

endpackage

// File: rtl/instruction_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface instruction_decode_stage_if #(
    parameter int INSTR_WIDTH = 32
);
    import common::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [INSTR_WIDTH-1:0]    in_instruction;
    logic [REGISTER_WIDTH-1:0] in_pc;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    instruction_t              out_decoded;
    logic [REGISTER_WIDTH-1:0] out_pc;
    logic [REGISTER_WIDTH-1:0] out_imm;
    logic                      out_illegal;

    modport master (
        output in_valid, in_instruction, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_decoded, out_pc, out_imm, out_illegal
    );

    modport slave (
        input  in_valid, in_instruction, in_pc, flush, out_ready,
        output in_ready, out_valid, out_decoded, out_pc, out_imm, out_illegal
    );

endinterface

// File: rtl/instruction_decode_stage_immediate_generator.sv
// Combinational RV32I immediate extraction for the I/S/B/U/J formats; IMM_NONE yields zero.
module immediate_generator
    import common::*;
#(
    parameter int INSTR_WIDTH = 32
) (
    input  logic [INSTR_WIDTH-1:0]    instruction,
    input  imm_type_t                 imm_type,
    output logic [REGISTER_WIDTH-1:0] imm
);

    logic unused_opcode_bits;
    assign unused_opcode_bits = ^instruction[6:0];

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I: imm = {{(REGISTER_WIDTH-11){instruction[31]}}, instruction[30:20]};
            IMM_S: imm = {{(REGISTER_WIDTH-11){instruction[31]}}, instruction[30:25], instruction[11:7]};
            IMM_B: imm = {{(REGISTER_WIDTH-12){instruction[31]}}, instruction[7], instruction[30:25],
                          instruction[11:8], 1'b0};
            IMM_U: imm = {instruction[31:12], 12'b0};
            IMM_J: imm = {{(REGISTER_WIDTH-20){instruction[31]}}, instruction[19:12], instruction[20],
                          instruction[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// RV32I decode stage: registered decoded fields, immediate and illegal flag behind valid/ready.
// Define DECODE_SKID_BUFFER_EN for a one-entry input skid register (no out_ready -> in_ready path).
module instruction_decode_stage
    import common::*;
#(
    parameter int INSTR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instruction_decode_stage_if.slave bus
);

    logic                      load_out;
    logic                      accept;
    logic                      load_new;
    logic [INSTR_WIDTH-1:0]    dec_word;
    logic [REGISTER_WIDTH-1:0] dec_pc;
    logic [REGISTER_WIDTH-1:0] dec_imm;
    imm_type_t                 dec_type;
    logic                      dec_illegal;
    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic [6:0]                funct7;

    logic                      out_valid_q;
    instruction_t              out_decoded_q;
    logic [REGISTER_WIDTH-1:0] out_pc_q;
    logic [REGISTER_WIDTH-1:0] out_imm_q;
    logic                      out_illegal_q;

    assign load_out = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && bus.in_ready;

`ifdef DECODE_SKID_BUFFER_EN
    logic                      skid_empty;
    logic [INSTR_WIDTH-1:0]    skid_word;
    logic [REGISTER_WIDTH-1:0] skid_pc;

    // A word accepted while the output stalls parks here; in_ready is this flop alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_empty <= 1'b1;
            skid_word  <= '0;
            skid_pc    <= '0;
        end else if (bus.flush) begin
            skid_empty <= 1'b1;
        end else if (accept && !load_out) begin
            skid_empty <= 1'b0;
            skid_word  <= bus.in_instruction;
            skid_pc    <= bus.in_pc;
        end else if (load_out) begin
            skid_empty <= 1'b1;
        end
    end

    assign bus.in_ready = skid_empty;
    assign dec_word     = skid_empty ? bus.in_instruction : skid_word;
    assign dec_pc       = skid_empty ? bus.in_pc : skid_pc;
    assign load_new     = !skid_empty || accept;
`else
    assign bus.in_ready = load_out;
    assign dec_word     = bus.in_instruction;
    assign dec_pc       = bus.in_pc;
    assign load_new     = accept;
`endif

    assign opcode = dec_word[6:0];
    assign funct3 = dec_word[14:12];
    assign funct7 = dec_word[31:25];

    always_comb begin
        dec_illegal = 1'b0;
        dec_type    = IMM_NONE;
        case (opcode)
            OPCODE_LUI, OPCODE_AUIPC:  dec_type = IMM_U;
            OPCODE_JAL:                dec_type = IMM_J;
            OPCODE_JALR, OPCODE_LOAD:  dec_type = IMM_I;
            OPCODE_BRANCH:             dec_type = IMM_B;
            OPCODE_STORE:              dec_type = IMM_S;
            OPCODE_SYSTEM:             dec_type = IMM_NONE;
            OPCODE_ARITH_IMM: begin
                dec_type = IMM_I;
                if (funct3 == FUNCT3_SLL && funct7 != FUNCT7_BASE)
                    dec_illegal = 1'b1;
                if (funct3 == FUNCT3_SRL_SRA && funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT)
                    dec_illegal = 1'b1;
            end
            OPCODE_ARITH: begin
                // The alternate funct7 only exists for SUB and SRA.
                if (funct7 == FUNCT7_ALT) begin
                    if (funct3 != FUNCT3_ADD_SUB && funct3 != FUNCT3_SRL_SRA)
                        dec_illegal = 1'b1;
                end else if (funct7 != FUNCT7_BASE) begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_word[1:0] != 2'b11)
            dec_illegal = 1'b1;
        if (dec_illegal)
            dec_type = IMM_NONE;
    end

    immediate_generator #(
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_imm_gen (
        .instruction (dec_word),
        .imm_type    (dec_type),
        .imm         (dec_imm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_decoded_q <= '0;
            out_pc_q      <= '0;
            out_imm_q     <= '0;
            out_illegal_q <= 1'b0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (load_out) begin
            out_valid_q <= load_new;
            if (load_new) begin
                out_decoded_q <= instruction_t'(dec_word);
                out_pc_q      <= dec_pc;
                out_imm_q     <= dec_imm;
                out_illegal_q <= dec_illegal;
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_decoded = out_decoded_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_imm     = out_imm_q;
    assign bus.out_illegal = out_illegal_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Scoreboard bench for instruction_decode_stage: hand-computed immediates/illegal flags, stall, flush, reset.
module tb_instruction_decode_stage;
    import common::*;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        ill;
    } stim_t;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        ill;
        int          acc_cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    instruction_decode_stage_if #(.INSTR_WIDTH(32)) bus ();

    instruction_decode_stage #(.INSTR_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    stim_t       stim_q[$];
    exp_t        exp_q[$];
    int          xfer_cyc[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    int          last_lat     = 0;
    logic        drv_en       = 1'b0;
    logic [31:0] pc_ctr       = 32'h0000_1000;
    stim_t       drv_s;
    exp_t        mon_e;

    logic        held = 1'b0;
    logic [31:0] h_pc, h_imm, h_dec;
    logic        h_ill;

    // word, expected imm, expected illegal
    localparam int NTBL = 17;
    logic [31:0] tbl_w   [NTBL] = '{32'h0040006F, 32'hFFFFF017, 32'h00008067, 32'h40000033, 32'h40005033,
                                    32'h40001033, 32'h40001013, 32'h40005013, 32'h00000073, 32'hFFC12083,
                                    32'h0000000B, 32'h00209463, 32'h00000000, 32'h0000007F, 32'h02000033,
                                    32'h00101093, 32'h02005013};
    logic [31:0] tbl_imm [NTBL] = '{32'h00000004, 32'hFFFFF000, 32'h0, 32'h0, 32'h0,
                                    32'h0, 32'h0, 32'h00000400, 32'h0, 32'hFFFFFFFC,
                                    32'h0, 32'h00000008, 32'h0, 32'h0, 32'h0,
                                    32'h00000001, 32'h0};
    logic        tbl_ill [NTBL] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                    1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                                    1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic [31:0] imm, input logic ill);
        stim_t s;
        s = '{w, pc_ctr, imm, ill};
        stim_q.push_back(s);
        pc_ctr = pc_ctr + 32'd4;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(tag, 32'(stim_q.size() + exp_q.size()), 32'd0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Driver: presents the stimulus head; acceptance decided away from the edge.
    initial begin
        bus.in_valid       = 1'b0;
        bus.in_instruction = '0;
        bus.in_pc          = '0;
        forever begin
            @(posedge clk);
            #1;
            if (drv_en) begin
                if (stim_q.size() > 0) begin
                    bus.in_valid       = 1'b1;
                    bus.in_instruction = stim_q[0].word;
                    bus.in_pc          = stim_q[0].pc;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (drv_en && rst_n && bus.in_valid && bus.in_ready && stim_q.size() > 0) begin
                drv_s = stim_q.pop_front();
                if (!bus.flush)
                    exp_q.push_back('{drv_s.word, drv_s.pc, drv_s.imm, drv_s.ill, cyc});
            end
        end
    end

    // Monitor: output-hold stability and scoreboard compare on each output transfer.
    always @(negedge clk) begin
        if (rst_n && held) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_pc", bus.out_pc, h_pc);
            chk("hold_imm", bus.out_imm, h_imm);
            chk("hold_dec", 32'(bus.out_decoded), h_dec);
            chk("hold_ill", 32'(bus.out_illegal), 32'(h_ill));
        end
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_pc", bus.out_pc, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_pc", bus.out_pc, mon_e.pc);
                chk("out_imm", bus.out_imm, mon_e.imm);
                chk("out_illegal", 32'(bus.out_illegal), 32'(mon_e.ill));
                chk("out_opcode", 32'(bus.out_decoded.opcode), 32'(mon_e.word[6:0]));
                chk("out_decoded", 32'(bus.out_decoded), mon_e.word);
                last_lat = cyc - mon_e.acc_cyc;
                xfer_cyc.push_back(cyc);
            end
        end
        held  <= rst_n && bus.out_valid && !bus.out_ready && !bus.flush;
        h_pc  <= bus.out_pc;
        h_imm <= bus.out_imm;
        h_dec <= 32'(bus.out_decoded);
        h_ill <= bus.out_illegal;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_out_imm", bus.out_imm, 32'd0);
        chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
        chk("rst_out_decoded", 32'(bus.out_decoded), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drv_en = 1'b1;

        // ADDI x1,x0,-1 and single-cycle latency
        push(32'hFFF00093, 32'hFFFFFFFF, 1'b0);
        drain("addi_drain");
        chk("addi_latency", 32'(last_lat), 32'd1);

        // SW, BEQ, LUI back to back with no bubble
        xfer_cyc.delete();
        push(32'h0020A423, 32'h00000008, 1'b0);
        push(32'hFE000EE3, 32'hFFFFFFFC, 1'b0);
        push(32'h123452B7, 32'h12345000, 1'b0);
        drain("b2b_drain");
        chk("b2b_count", 32'(xfer_cyc.size()), 32'd3);
        if (xfer_cyc.size() == 3)
            chk("b2b_span", 32'(xfer_cyc[2] - xfer_cyc[0]), 32'd2);

        // Format and legality table
        for (int i = 0; i < NTBL; i++) push(tbl_w[i], tbl_imm[i], tbl_ill[i]);
        drain("table_drain");

        // Stall three-plus cycles with input pending
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(tbl_w[i], tbl_imm[i], tbl_ill[i]);
        repeat (5) @(negedge clk);
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
`ifdef DECODE_SKID_BUFFER_EN
        chk("stall_accepted", 32'(4 - stim_q.size()), 32'd2);
`else
        chk("stall_accepted", 32'(4 - stim_q.size()), 32'd1);
`endif
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain("stall_drain");

        // Random back-pressure over the whole table
        for (int i = 0; i < NTBL; i++) push(tbl_w[i], tbl_imm[i], tbl_ill[i]);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1 bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
        drain("random_drain");

        // Flush while an output is held and a new word is offered
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        push(32'h00500113, 32'h00000005, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("flush_pre_valid", 32'(bus.out_valid), 32'd1);
        drv_en = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid       = 1'b1;
        bus.in_instruction = 32'h00700193;
        bus.in_pc          = 32'hBEEF_0000;
        bus.flush          = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("flush_stays_empty", 32'(bus.out_valid), 32'd0);
        drv_en = 1'b1;
        push(32'hFFC12083, 32'hFFFFFFFC, 1'b0);
        drain("post_flush_drain");

        // Asynchronous reset in the middle of a stall
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(tbl_w[i], tbl_imm[i], tbl_ill[i]);
        repeat (3) @(negedge clk);
        chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(bus.out_valid), 32'd0);
        stim_q.delete();
        exp_q.delete();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_rst_out_imm", bus.out_imm, 32'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        push(32'h123452B7, 32'h12345000, 1'b0);
        drain("post_rst_drain");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
